// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and reset defaults for the programmable timer
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Shadow defaults after reset: widest limit, fastest tick, periodic mode.
  // Stored at 32 bits and sliced down to the instance widths.
  localparam logic [31:0] LIMIT_RST = 32'hFFFF_FFFF;
  localparam logic [31:0] PRESC_RST = 32'd0;
  localparam logic        MODE_RST  = MODE_PERIODIC;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - divide-by-(div+1) tick generator
module timer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt;

  // A tick is only issued on enabled cycles so a frozen prescaler never fires.
  assign tick = en && (pcnt == div);

  // Prescale counter: clear has priority, wraps to zero on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/prog_timer.sv
// rtl/prog_timer.sv - programmable periodic/one-shot timer with shadowed config
module prog_timer
  import timer_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               load,
  input  logic [WIDTH-1:0]   cfg_limit,
  input  logic [PRESC_W-1:0] cfg_presc,
  input  logic               cfg_mode,
  input  logic               start,
  input  logic               stop,
  input  logic               clr_irq,
  output logic [WIDTH-1:0]   count,
  output logic               running,
  output logic               wrap,
  output logic               irq
);

  state_t             state;

  logic [WIDTH-1:0]   shd_limit;
  logic [PRESC_W-1:0] shd_presc;
  logic               shd_mode;

  logic [WIDTH-1:0]   act_limit;
  logic [PRESC_W-1:0] act_presc;
  logic               act_mode;

  logic               tick;
  logic               presc_en;
  logic               presc_clr;
  logic               wrap_evt;

  // Prescaler only advances while counting; start and stop realign it to zero.
  assign presc_en  = (state == RUN) && en;
  assign presc_clr = start || stop;

  // Terminal tick that is not overridden by a same-cycle start or stop.
  assign wrap_evt  = !stop && !start && (state == RUN) && tick && (count == act_limit);

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (presc_clr),
    .en    (presc_en),
    .div   (act_presc),
    .tick  (tick)
  );

  // Shadow capture: a load strobe parks new config until the next reload point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_limit <= LIMIT_RST[WIDTH-1:0];
      shd_presc <= PRESC_RST[PRESC_W-1:0];
      shd_mode  <= MODE_RST;
    end else if (load) begin
      shd_limit <= cfg_limit;
      shd_presc <= cfg_presc;
      shd_mode  <= cfg_mode;
    end
  end

  // Control FSM, counter and active config; stop beats start, start beats tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      running   <= 1'b0;
      count     <= '0;
      wrap      <= 1'b0;
      act_limit <= LIMIT_RST[WIDTH-1:0];
      act_presc <= PRESC_RST[PRESC_W-1:0];
      act_mode  <= MODE_RST;
    end else begin
      wrap <= 1'b0;
      if (stop) begin
        state   <= IDLE;
        running <= 1'b0;
        count   <= '0;
      end else if (start) begin
        state   <= RUN;
        running <= 1'b1;
        count   <= '0;
        // A load in the same cycle bypasses straight into the actives.
        if (load) begin
          act_limit <= cfg_limit;
          act_presc <= cfg_presc;
          act_mode  <= cfg_mode;
        end else begin
          act_limit <= shd_limit;
          act_presc <= shd_presc;
          act_mode  <= shd_mode;
        end
      end else if ((state == RUN) && tick) begin
        if (wrap_evt) begin
          wrap <= 1'b1;
          if (act_mode == MODE_ONESHOT) begin
            state   <= DONE;
            running <= 1'b0;
          end else begin
            count     <= '0;
            act_limit <= shd_limit;
            act_presc <= shd_presc;
            act_mode  <= shd_mode;
          end
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  // Sticky interrupt: a wrap sets it and wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else if (wrap_evt) begin
      irq <= 1'b1;
    end else if (clr_irq) begin
      irq <= 1'b0;
    end
  end

endmodule

// File: doc/prog_timer.md
Name: prog_timer

Overview:
- Parametrised, programmable successor to the fixed-limit free-running timer.
- Adds a runtime-loadable compare limit, a programmable prescaler, periodic/one-shot modes, start/stop control and a sticky interrupt flag.
- Used by the digital-design demos as the common tick and timeout source.
- Configuration is shadowed, so reprogramming never corrupts a count in flight.

Parameters:
- WIDTH, 32, counter and limit width in bits (2..32).
- PRESC_W, 8, prescaler divisor width; the tick rate is clk/(presc+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global enable; low freezes prescaler and counter only.
- load  in  1  1-cycle strobe; captures cfg_* into the shadow registers.
- cfg_limit  in  WIDTH  terminal count value.
- cfg_presc  in  PRESC_W  prescaler divisor minus one.
- cfg_mode  in  1  0 = periodic, 1 = one-shot.
- start  in  1  1-cycle strobe; begin counting.
- stop  in  1  1-cycle strobe; halt and return to idle.
- clr_irq  in  1  clears the irq flag.
- count  out  WIDTH  current count value.
- running  out  1  high in the RUN state.
- wrap  out  1  1-cycle pulse on the tick where count == limit.
- irq  out  1  sticky flag, set on every wrap pulse.

Behaviour:
- Reset (asynchronous, rst_n low) clears:
  - count = 0, running = 0, wrap = 0, irq = 0, prescaler counter = 0, state = IDLE.
  - Shadow registers: limit = {WIDTH{1'b1}}, presc = 0, mode = periodic.
- Reset mid-count aborts immediately. No residual pulse after release.
- Shadow registers: a load cycle copies cfg_* into the shadows. Active registers (act_limit, act_presc, act_mode) update from the shadows:
  - on start accepted from IDLE or DONE;
  - on every periodic wrap.
  - A load during RUN therefore takes effect at the next wrap, never mid-period.
- Prescaler:
  - pcnt increments only when state == RUN and en == 1.
  - tick = (pcnt == act_presc). On tick, pcnt returns to 0.
  - act_presc = 0 gives a tick every enabled cycle.
- State machine (IDLE, RUN, DONE):
  - IDLE: start -> RUN. Count = 0, pcnt = 0, actives loaded.
  - RUN, tick with count != act_limit: count <= count + 1.
  - RUN, tick with count == act_limit: wrap = 1 for one cycle, irq <= 1.
    - Periodic: count <= 0, actives reloaded, stay in RUN.
    - One-shot: count holds at act_limit, state -> DONE.
  - RUN, stop: -> IDLE, count <= 0, pcnt <= 0. No wrap, even if a tick coincides.
  - DONE: count holds. start -> RUN as from IDLE. stop -> IDLE with count = 0.
- running = (state == RUN), registered with the state.
- Latency:
  - The first increment occurs act_presc+1 enabled cycles after the start cycle.
  - Period = (act_limit+1)*(act_presc+1) enabled cycles.
- Boundary cases:
  - act_limit = 0: every tick is a wrap, and count stays 0.
  - act_limit = all-ones: count never overflows past the limit, no arithmetic wrap.
  - start and stop in the same cycle: stop wins.
  - start while RUN: restarts. count = 0, pcnt = 0, shadows reloaded.
  - load and start in the same cycle: start uses the new cfg_* values (load bypasses to the actives).
  - clr_irq and wrap in the same cycle: irq stays 1 (set wins).
  - en low: pcnt and count freeze. start, stop, load and clr_irq still act.
  - Counter addition is WIDTH bits; the carry is discarded.

Decomposition:
- Package timer_pkg:
  - state enum (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2).
  - mode constants MODE_PERIODIC = 1'b0, MODE_ONESHOT = 1'b1.
  - Reset defaults for the shadow registers.
- Sub-module timer_prescaler (PRESC_W):
  - inputs clk, rst_n, clr, en, div; output tick.
  - Owns pcnt.
- The top level holds the shadow/active registers, FSM and counter.

Test Plan:
1. Reset: hold rst_n low mid-run with count = 5 -> count, irq, running and wrap go to 0 asynchronously; after release, state stays IDLE until start.
2. Periodic: load limit = 3, presc = 1, mode = 0, then start -> count steps every 2 cycles through 0,1,2,3,0. First wrap fires 8 cycles after start, then every 8 cycles; irq is set.
3. One-shot: limit = 2, presc = 0, mode = 1, start -> count 0,1,2, then holds at 2. One wrap pulse, state DONE, running = 0. A second start restarts from 0.
4. Shadow reload: periodic limit = 4 running; load limit = 1 when count = 2 -> this period still wraps at 4, subsequent periods wrap at 1.
5. Collisions: start and stop in the same cycle -> IDLE. clr_irq on the wrap cycle -> irq stays 1. clr_irq one cycle later -> irq = 0.
6. en gating: periodic limit = 3, presc = 0; deassert en for 5 cycles at count = 1 -> count holds at 1; it resumes and wraps 3 enabled cycles after en returns.
